// File: rtl/delay_gate_net.sv
// N-input AND/OR/XOR reduction gate whose result reaches out after a programmable delay (transport or inertial).
// Latency: dly+1 clock edges from an input change to out, in both modes.
// No backpressure: every cycle is accepted; narrow pulses are swallowed and counted in inertial mode.
module delay_gate_net #(
    parameter int WIDTH     = 2,
    parameter int OP        = 0,
    parameter int MAX_DELAY = 16,
    parameter int DW        = $clog2(MAX_DELAY)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic [DW-1:0]    dly,
    input  logic             mode,
    output logic             out,
    output logic             pending,
    output logic [7:0]       glitch_cnt
);

    logic                 g;
    logic [MAX_DELAY-1:1] hist_q, hist_d;
    logic [MAX_DELAY-1:0] taps;
    logic [DW-1:0]        cnt_q, cnt_d;
    logic                 out_q, out_d;
    logic                 mode_q, mode_d;
    logic [7:0]           glitch_q, glitch_d;

    always_comb begin
        case (OP)
            1:       g = |in;
            2:       g = ^in;
            default: g = &in;
        endcase
    end

    always_comb begin
        hist_d    = hist_q;
        hist_d[1] = g;
        for (int k = 2; k < MAX_DELAY; k++) begin
            hist_d[k] = hist_q[k-1];
        end
        // Tap 0 is the live gate value, so dly=0 gives a single-edge latency.
        taps     = {hist_q, g};
        out_d    = out_q;
        cnt_d    = cnt_q;
        glitch_d = glitch_q;
        mode_d   = mode;
        if (!mode) begin
            out_d = taps[dly];
            cnt_d = '0;
        end else if (!mode_q) begin
            // First inertial edge after a mode change: restart qualification, count nothing.
            cnt_d = '0;
        end else if (g == out_q) begin
            if (cnt_q != '0) begin
                cnt_d = '0;
                if (glitch_q != 8'hFF) glitch_d = glitch_q + 8'd1;
            end
        end else if (cnt_q >= dly) begin
            out_d = g;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hist_q   <= '0;
            cnt_q    <= '0;
            out_q    <= 1'b0;
            mode_q   <= 1'b0;
            glitch_q <= '0;
        end else begin
            hist_q   <= hist_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            mode_q   <= mode_d;
            glitch_q <= glitch_d;
        end
    end

    assign out        = out_q;
    assign pending    = (cnt_q != '0);
    assign glitch_cnt = glitch_q;

endmodule
